mmu_sequencer: RTL and testbench
================================

// Module: mmu_sequencer
// PURPOSE
//  Front-end controller for the 2x2 MMU feeder. Accepts a host byte stream of 4 weights + 4 inputs,
//  holds them in operand registers, then drives the feeder's en / mmu_cycles schedule for one
//  matmul pass and signals completion. Sits between the host load interface and the feeder.
// PARAMETERS
//  DATA_W    8  operand byte width
//  N_ELEM    4  operands per matrix (2x2)
//  RUN_LAST  6  final mmu_cycles value of a pass (0..5 active schedule, 6 = drain)
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst           in   1       synchronous reset, active-high
//  load_valid    in   1       host byte valid
//  load_ready    out  1       sequencer accepts byte (transfer = valid & ready)
//  load_data     in   DATA_W  host byte; order: w0,w1,w2,w3,i0,i1,i2,i3
//  reuse_w       in   1       sampled on first accepted byte of a load (see CONFIGURATION)
//  abort         in   1       synchronous abort of load or run
//  weight_0..3   out  DATA_W  registered weights to feeder
//  input_0..3    out  DATA_W  registered inputs to feeder
//  mmu_en        out  1       feeder enable
//  mmu_cycles    out  3       feeder schedule step
//  busy          out  1       high in LOAD or RUN
//  done          out  1       one-cycle pulse at end of pass
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, all operand regs 0, byte count 0, mmu_en=0, mmu_cycles=0,
//   done=0. Outputs: load_ready=1, busy=0.
//  States: IDLE -> LOAD -> RUN -> IDLE.
//  IDLE: load_ready=1. First accepted byte written to weight_0 (or input_0 if reuse active),
//   count=1, go LOAD.
//  LOAD: load_ready=1; each transfer writes next slot in order, count++. Transfer of final slot
//   (i3) -> RUN next cycle with mmu_cycles=0. No byte gaps required; load_valid=0 simply stalls.
//  RUN: load_ready=0, mmu_en=1, mmu_cycles steps 0,1,...,RUN_LAST, one per cycle (7 cycles).
//   Step RUN_LAST is the drain cycle so the feeder's registered c_3 output is presented.
//   Leaving RUN: mmu_en=0, mmu_cycles=0, done=1 for exactly the first IDLE cycle.
//  Operand regs never change outside accepted transfers; stable for whole RUN.
//  busy = (state != IDLE); combinational from state.
//  abort: in LOAD or RUN -> IDLE next cycle, count=0, mmu_en=0, mmu_cycles=0, no done pulse;
//   operand regs retained. abort in IDLE: no effect, and any same-cycle byte is NOT accepted
//   (load_ready forced 0 while abort=1). abort wins over a simultaneous final-byte transfer.
//  rst mid-operation: full reset values, regs cleared, regardless of state.
//  mmu_cycles never exceeds RUN_LAST; no wrap.
// CONFIGURATION
//  MMU_SEQ_WEIGHT_REUSE_EN defined: if reuse_w=1 on the first accepted byte, weight regs are kept
//   and the load is only i0..i3 (4 bytes) before RUN. reuse_w ignored on later bytes.
//  Not defined: reuse_w ignored; every load is the full 8-byte sequence.
// STRUCTURE
//  Package mmu_pkg: state enum (IDLE/LOAD/RUN), DATA_W, N_ELEM, RUN_LAST, mmu_cycles width,
//   load-slot index constants (SLOT_W0..SLOT_I3).
//  Single module; no sub-module (operand register file is 8 byte regs addressed by count).
// TESTING
//  1 Reset, then stream 1..8 back-to-back -> weight_0..3=1..4, input_0..3=5..8; RUN next cycle,
//    mmu_cycles 0..6 on 7 consecutive cycles, mmu_en=1 throughout, then done=1 for one cycle.
//  2 Gapped stream (load_valid low 3 cycles between bytes) -> same register contents, RUN starts
//    the cycle after 8th byte only.
//  3 load_valid held high during RUN with data 0xFF -> load_ready=0, no register changes.
//  4 abort at mmu_cycles=3 -> next cycle IDLE, mmu_en=0, no done pulse, operands unchanged;
//    abort asserted with 8th byte -> stays IDLE-bound, no RUN.
//  5 Assert rst during LOAD after 5 bytes -> all regs 0, busy=0; fresh 8-byte load works.
//  6 MMU_SEQ_WEIGHT_REUSE_EN: load 1..8, run; then reuse_w=1 with bytes 9..12 -> weights stay
//    1..4, inputs 9..12, RUN after 4th byte. Without macro same stimulus -> weights 9..12, waits
//    for 4 more bytes.

Source files
------------

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared definitions for the MMU feeder front-end sequencer.
//   state_t          : sequencer phase (IDLE / LOAD / RUN)
//   DATA_W           : operand byte width
//   N_ELEM           : operands per 2x2 matrix
//   CYC_W / RUN_LAST : width and final value of the feeder schedule step
//   SLOT_*           : operand slot index in host byte order w0..w3, i0..i3
package mmu_pkg;

   localparam int DATA_W = 8;
   localparam int N_ELEM = 4;
   localparam int N_SLOT = 2 * N_ELEM;
   localparam int CYC_W  = 3;
   localparam int SLOT_W = 3;

   // Steps 0..5 are the active schedule, step 6 drains the feeder's c_3 register.
   localparam logic [CYC_W-1:0] RUN_LAST = 3'd6;

   localparam logic [SLOT_W-1:0] SLOT_W0 = 3'd0;
   localparam logic [SLOT_W-1:0] SLOT_W1 = 3'd1;
   localparam logic [SLOT_W-1:0] SLOT_W2 = 3'd2;
   localparam logic [SLOT_W-1:0] SLOT_W3 = 3'd3;
   localparam logic [SLOT_W-1:0] SLOT_I0 = 3'd4;
   localparam logic [SLOT_W-1:0] SLOT_I1 = 3'd5;
   localparam logic [SLOT_W-1:0] SLOT_I2 = 3'd6;
   localparam logic [SLOT_W-1:0] SLOT_I3 = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/mmu_sequencer.sv
// mmu_sequencer: loads 4 weights + 4 inputs from a host byte stream, then
// drives the 2x2 MMU feeder schedule for one pass and pulses done.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   load_valid/ready/data    : host byte stream (order w0..w3, i0..i3)
//   reuse_w                  : keep weights for this load (first byte only)
//   abort                    : drop the current load or run, back to IDLE
//   weight_0..3, input_0..3  : operand registers presented to the feeder
//   mmu_en, mmu_cycles       : feeder enable and schedule step
//   busy, done               : in LOAD/RUN; one-cycle end-of-pass pulse
// Build option: define MMU_SEQ_WEIGHT_REUSE_EN to honour reuse_w; otherwise
// every load is the full 8-byte sequence.
module mmu_sequencer
   import mmu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic              reuse_w,
   input  logic              abort,
   output logic [DATA_W-1:0] weight_0,
   output logic [DATA_W-1:0] weight_1,
   output logic [DATA_W-1:0] weight_2,
   output logic [DATA_W-1:0] weight_3,
   output logic [DATA_W-1:0] input_0,
   output logic [DATA_W-1:0] input_1,
   output logic [DATA_W-1:0] input_2,
   output logic [DATA_W-1:0] input_3,
   output logic              mmu_en,
   output logic [CYC_W-1:0]  mmu_cycles,
   output logic              busy,
   output logic              done
);

   state_t              state_q, state_d;
   logic [SLOT_W-1:0]   count_q, count_d;
   logic [CYC_W-1:0]    cycles_q, cycles_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   regs_q [N_SLOT];
   logic [DATA_W-1:0]   regs_d [N_SLOT];

   logic                reuse_sel;
   logic                xfer;
   logic [SLOT_W-1:0]   first_slot;

`ifdef MMU_SEQ_WEIGHT_REUSE_EN
   assign reuse_sel = reuse_w;
`else
   logic unused_reuse_w;
   assign unused_reuse_w = reuse_w;
   assign reuse_sel      = 1'b0;
`endif

   // abort masks ready so a byte offered alongside abort is never taken.
   assign load_ready = (state_q != RUN) && !abort;
   assign xfer       = load_valid && load_ready;
   assign first_slot = reuse_sel ? SLOT_I0 : SLOT_W0;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      cycles_d = cycles_q;
      done_d   = 1'b0;
      regs_d   = regs_q;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               regs_d[first_slot] = load_data;
               count_d            = first_slot + 3'd1;
               state_d            = LOAD;
            end
         end
         LOAD: begin
            if (abort) begin
               state_d = IDLE;
               count_d = '0;
            end else if (xfer) begin
               regs_d[count_q] = load_data;
               if (count_q == SLOT_I3) begin
                  state_d  = RUN;
                  count_d  = '0;
                  cycles_d = '0;
               end else begin
                  count_d = count_q + 3'd1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d  = IDLE;
               cycles_d = '0;
            end else if (cycles_q == RUN_LAST) begin
               state_d  = IDLE;
               cycles_d = '0;
               done_d   = 1'b1;
            end else begin
               cycles_d = cycles_q + 3'd1;
            end
         end
         default: begin
            state_d  = IDLE;
            count_d  = '0;
            cycles_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         cycles_q <= '0;
         done_q   <= 1'b0;
         for (int i = 0; i < N_SLOT; i++) regs_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         cycles_q <= cycles_d;
         done_q   <= done_d;
         regs_q   <= regs_d;
      end
   end

   assign weight_0   = regs_q[SLOT_W0];
   assign weight_1   = regs_q[SLOT_W1];
   assign weight_2   = regs_q[SLOT_W2];
   assign weight_3   = regs_q[SLOT_W3];
   assign input_0    = regs_q[SLOT_I0];
   assign input_1    = regs_q[SLOT_I1];
   assign input_2    = regs_q[SLOT_I2];
   assign input_3    = regs_q[SLOT_I3];
   assign mmu_en     = (state_q == RUN);
   assign mmu_cycles = cycles_q;
   assign busy       = (state_q != IDLE);
   assign done       = done_q;

endmodule

// File: tb/tb_mmu_sequencer.sv
// tb_mmu_sequencer: directed + randomized stimulus against a byte-level
// reference model; completed passes are queued and checked when done pulses.
module tb_mmu_sequencer;
   import mmu_pkg::*;

`ifdef MMU_SEQ_WEIGHT_REUSE_EN
   localparam bit REUSE_EN = 1'b1;
`else
   localparam bit REUSE_EN = 1'b0;
`endif
   localparam int RUN_LEN = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, load_valid, reuse_w, abort;
   logic [DATA_W-1:0] load_data;
   logic              load_ready, mmu_en, busy, done;
   logic [CYC_W-1:0]  mmu_cycles;
   logic [DATA_W-1:0] weight_0, weight_1, weight_2, weight_3;
   logic [DATA_W-1:0] input_0, input_1, input_2, input_3;

   mmu_sequencer dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .reuse_w(reuse_w), .abort(abort),
      .weight_0(weight_0), .weight_1(weight_1), .weight_2(weight_2), .weight_3(weight_3),
      .input_0(input_0), .input_1(input_1), .input_2(input_2), .input_3(input_3),
      .mmu_en(mmu_en), .mmu_cycles(mmu_cycles), .busy(busy), .done(done)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: bytes collected so far, cycles of RUN still to go.
   logic [7:0]  m_regs [8];
   bit          m_loading;
   int          m_idx;
   int          m_run_left;
   bit          m_done;
   logic [63:0] exp_q [$];

   function automatic logic [63:0] model_ops();
      return {m_regs[0], m_regs[1], m_regs[2], m_regs[3],
              m_regs[4], m_regs[5], m_regs[6], m_regs[7]};
   endfunction

   function automatic logic [63:0] dut_ops();
      return {weight_0, weight_1, weight_2, weight_3,
              input_0, input_1, input_2, input_3};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // One clock: advance the model on what was driven, then compare.
   task automatic step();
      @(posedge clk);
      m_done = 1'b0;
      if (rst) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
         m_loading  = 1'b0;
         m_idx      = 0;
         m_run_left = 0;
         exp_q.delete();
      end else if (m_run_left > 0) begin
         if (abort) m_run_left = 0;
         else begin
            m_run_left--;
            if (m_run_left == 0) begin
               m_done = 1'b1;
               exp_q.push_back(model_ops());
            end
         end
      end else if (abort) begin
         m_loading = 1'b0;
      end else if (load_valid) begin
         if (!m_loading) begin
            m_loading = 1'b1;
            m_idx     = (REUSE_EN && reuse_w) ? 4 : 0;
         end
         m_regs[m_idx] = load_data;
         m_idx++;
         if (m_idx == 8) begin
            m_loading  = 1'b0;
            m_run_left = RUN_LEN;
         end
      end
      #1;
      chk("busy",       64'(busy),       64'(m_loading || m_run_left > 0));
      chk("mmu_en",     64'(mmu_en),     64'(m_run_left > 0));
      chk("mmu_cycles", 64'(mmu_cycles), 64'((m_run_left > 0) ? RUN_LEN - m_run_left : 0));
      chk("done",       64'(done),       64'(m_done));
      chk("load_ready", 64'(load_ready), 64'(!abort && m_run_left == 0));
      chk("operands",   dut_ops(),       model_ops());
      $display("cyc rst=%0b v=%0b d=%02h ab=%0b rw=%0b | rdy=%0b busy=%0b en=%0b cyc=%0d done=%0b",
               rst, load_valid, load_data, abort, reuse_w, load_ready, busy, mmu_en, mmu_cycles, done);
   endtask

   // Scoreboard monitor: every done pulse must match a queued completed pass.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
         else chk("pass_operands", dut_ops(), exp_q.pop_front());
      end
   end

   task automatic send(input logic [7:0] d);
      load_valid = 1'b1;
      load_data  = d;
      step();
      load_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   initial begin
      rst = 1'b1; load_valid = 1'b0; load_data = '0; reuse_w = 1'b0; abort = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'hxx;
      m_loading = 1'b0; m_idx = 0; m_run_left = 0; m_done = 1'b0;
      idle(2);
      rst = 1'b0;
      chk("reset_ready", 64'(load_ready), 64'd1);
      chk("reset_ops",   dut_ops(),       64'd0);

      // Back-to-back load 1..8, full run.
      for (int i = 1; i <= 8; i++) send(8'(i));
      idle(9);

      // Gapped load.
      for (int i = 1; i <= 8; i++) begin
         send(8'(i + 16));
         idle(3);
      end
      idle(6);

      // Host keeps offering 0xFF during RUN.
      for (int i = 1; i <= 8; i++) send(8'(i + 32));
      load_valid = 1'b1; load_data = 8'hFF;
      idle(RUN_LEN);
      load_valid = 1'b0;
      idle(2);

      // Abort at mmu_cycles=3, then abort alongside the final byte.
      for (int i = 1; i <= 8; i++) send(8'(i + 48));
      idle(3);
      abort = 1'b1; step(); abort = 1'b0;
      idle(3);
      for (int i = 1; i <= 7; i++) send(8'(i + 64));
      abort = 1'b1; send(8'h48); abort = 1'b0;
      idle(9);

      // Abort in IDLE with a byte offered.
      abort = 1'b1; send(8'h77); abort = 1'b0;
      idle(2);

      // Reset mid-load, then a fresh load.
      for (int i = 1; i <= 5; i++) send(8'(i + 80));
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 1; i <= 8; i++) send(8'(i + 96));
      idle(9);

      // Weight reuse request after a full pass.
      for (int i = 1; i <= 8; i++) send(8'(i));
      idle(9);
      reuse_w = 1'b1; send(8'd9); reuse_w = 1'b0;
      for (int i = 10; i <= 12; i++) send(8'(i));
      idle(9);
      for (int i = 13; i <= 16; i++) send(8'(i));
      idle(9);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         rst        = ($urandom_range(0, 199) == 0);
         abort      = ($urandom_range(0, 24) == 0);
         load_valid = ($urandom_range(0, 2) != 0);
         reuse_w    = ($urandom_range(0, 3) == 0);
         load_data  = 8'($urandom);
         step();
      end
      rst = 1'b0; abort = 1'b0; load_valid = 1'b0; reuse_w = 1'b0;
      idle(10);

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
